// File: rtl/cvita_deframer.sv
`timescale 1ns/1ps
// CVITA deframer: strips the header word (and optional VITA time word) from a
// 64-bit CVITA packet stream and emits 32-bit payload samples with sideband.
module cvita_deframer #(
  parameter bit CHECK_SEQNUM = 1'b1,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [63:0]          i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [31:0]          o_tdata,
  output logic [127:0]         o_tuser,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 len_err,
  output logic                 seq_err,
  output logic                 drop_stb,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {S_HDR, S_TIME, S_BODY, S_DROP} state_t;

  state_t                 state_q, state_d;
  logic [63:0]            hdr_q, hdr_d;
  logic [63:0]            time_q, time_d;
  logic [63:0]            hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   half_q, half_d;
  logic                   single_q, single_d;
  logic                   last_q, last_d;
  logic [15:0]            rem_q, rem_d;
  logic                   seq_armed_q, seq_armed_d;
  logic [11:0]            seq_exp_q, seq_exp_d;
  logic                   len_err_q, len_err_d;
  logic                   seq_err_q, seq_err_d;
  logic                   drop_q, drop_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   up_q;

  logic                   rdy;
  logic                   in_beat;
  logic                   on_last_half;
  logic signed [17:0]     pay_bytes;
  logic                   hdr_bad;
  logic                   final_cnt;

  // The half being presented is the last one of the held word.
  assign on_last_half = half_q | single_q;

  assign pay_bytes = $signed({2'b00, i_tdata[47:32]}) - (i_tdata[61] ? 18'sd16 : 18'sd8);
  assign hdr_bad   = (i_tdata[63:62] != 2'b00) | (pay_bytes <= 18'sd0) |
                     (i_tdata[33:32] != 2'b00);
  assign final_cnt = (rem_q <= 16'd8);

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      S_HDR, S_TIME: rdy = ~hold_valid_q;
      S_BODY:        rdy = ~hold_valid_q | (o_tready & on_last_half);
      S_DROP:        rdy = 1'b1;
      default:       rdy = 1'b0;
    endcase
  end

  // up_q keeps the input closed until the first edge after reset is released.
  assign i_tready = up_q & rdy;
  assign in_beat  = i_tvalid & i_tready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d      = state_q;
    hdr_d        = hdr_q;
    time_d       = time_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    half_d       = half_q;
    single_d     = single_q;
    last_d       = last_q;
    rem_d        = rem_q;
    seq_armed_d  = seq_armed_q;
    seq_exp_d    = seq_exp_q;
    len_err_d    = 1'b0;
    seq_err_d    = 1'b0;
    drop_d       = 1'b0;

    if (hold_valid_q && o_tready) begin
      if (on_last_half) hold_valid_d = 1'b0;
      else              half_d       = 1'b1;
    end

    case (state_q)
      S_HDR: begin
        if (in_beat) begin
          hdr_d  = i_tdata;
          time_d = '0;
          if (hdr_bad) begin
            drop_d    = 1'b1;
            len_err_d = (i_tdata[33:32] != 2'b00);
            state_d   = i_tlast ? S_HDR : S_DROP;
          end else begin
            if (CHECK_SEQNUM) begin
              seq_err_d   = seq_armed_q && (i_tdata[59:48] != seq_exp_q);
              seq_exp_d   = i_tdata[59:48] + 12'd1;
              seq_armed_d = 1'b1;
            end
            rem_d = pay_bytes[15:0];
            if (i_tlast) begin
              len_err_d = 1'b1;
              state_d   = S_HDR;
            end else begin
              state_d = i_tdata[61] ? S_TIME : S_BODY;
            end
          end
        end
      end

      S_TIME: begin
        if (in_beat) begin
          time_d = i_tdata;
          if (i_tlast) begin
            len_err_d = 1'b1;
            state_d   = S_HDR;
          end else begin
            state_d = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (in_beat) begin
          hold_d       = i_tdata;
          hold_valid_d = 1'b1;
          half_d       = 1'b0;
          last_d       = 1'b0;
          single_d     = 1'b0;
          if (i_tlast) begin
            // An early tlast still closes the packet on this word, both halves out.
            last_d    = 1'b1;
            single_d  = final_cnt && (rem_q == 16'd4);
            len_err_d = ~final_cnt;
            state_d   = S_HDR;
          end else if (final_cnt) begin
            last_d    = 1'b1;
            single_d  = (rem_q == 16'd4);
            len_err_d = 1'b1;
            state_d   = S_DROP;
          end else begin
            rem_d = rem_q - 16'd8;
          end
        end
      end

      S_DROP: begin
        if (in_beat && i_tlast) state_d = S_HDR;
      end

      default: state_d = S_HDR;
    endcase

    if (clear) begin
      seq_armed_d = 1'b0;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (clear) begin
      err_count_d = '0;
    end else if ((len_err_q | seq_err_q | drop_q) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HDR;
      hdr_q        <= '0;
      time_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      half_q       <= 1'b0;
      single_q     <= 1'b0;
      last_q       <= 1'b0;
      rem_q        <= '0;
      seq_armed_q  <= 1'b0;
      seq_exp_q    <= '0;
      len_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      drop_q       <= 1'b0;
      err_count_q  <= '0;
      up_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      time_q       <= time_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      half_q       <= half_d;
      single_q     <= single_d;
      last_q       <= last_d;
      rem_q        <= rem_d;
      seq_armed_q  <= seq_armed_d;
      seq_exp_q    <= seq_exp_d;
      len_err_q    <= len_err_d;
      seq_err_q    <= seq_err_d;
      drop_q       <= drop_d;
      err_count_q  <= err_count_d;
      up_q         <= 1'b1;
    end
  end

  assign o_tvalid  = hold_valid_q;
  assign o_tdata   = half_q ? hold_q[31:0] : hold_q[63:32];
  assign o_tlast   = hold_valid_q & last_q & on_last_half;
  assign o_tuser   = {hdr_q, time_q};
  assign len_err   = len_err_q;
  assign seq_err   = seq_err_q;
  assign drop_stb  = drop_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_cvita_deframer.sv
`timescale 1ns/1ps
// Bench for cvita_deframer: directed vector table, seqnum/saturation/reset
// sequences, and random packets checked against a packet-level model.
module tb_cvita_deframer;

  logic         clk = 1'b0;
  logic         reset, clear;
  logic [63:0]  i_tdata;
  logic         i_tlast, i_tvalid, i_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast, o_tvalid, o_tready;
  logic         len_err, seq_err, drop_stb;
  logic [15:0]  err_count;
  logic         i_tready2, o_tlast2, o_tvalid2, len_err2, seq_err2, drop_stb2;
  logic [31:0]  o_tdata2;
  logic [127:0] o_tuser2;
  logic [1:0]   err_count2;

  always #5 clk = ~clk;

  cvita_deframer dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .len_err(len_err), .seq_err(seq_err), .drop_stb(drop_stb),
    .err_count(err_count));

  // Narrow counter instance exercises saturation.
  cvita_deframer #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready2),
    .o_tdata(o_tdata2), .o_tuser(o_tuser2), .o_tlast(o_tlast2), .o_tvalid(o_tvalid2),
    .o_tready(o_tready), .len_err(len_err2), .seq_err(seq_err2), .drop_stb(drop_stb2),
    .err_count(err_count2));

  typedef struct {
    logic [31:0]  data;
    logic         last;
    logic [127:0] user;
  } smp_t;

  typedef struct {
    logic [63:0]       hdr;
    logic [2:0][63:0]  w;
    int                nw;
    int                ns;
    logic [3:0][31:0]  s;
    int                le;
    int                dr;
    int                ec;
  } vec_t;

  smp_t        rx_q[$];
  smp_t        exp_q[$];
  logic [63:0] tx_q[$];
  vec_t        vt[11];
  int          len_cnt = 0, seq_cnt = 0, drop_cnt = 0, stall_viol = 0;
  int          total = 0, bad = 0;
  bit          rand_rdy = 1'b0;
  bit          m_armed;
  logic [11:0] m_exp;
  int          e_len, e_seq, e_drop, e_ecnt;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: records accepted samples, error pulses and stall stability.
  initial begin
    bit           prev_stall;
    logic [31:0]  prev_d;
    logic [127:0] prev_u;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!o_tvalid || o_tdata !== prev_d || o_tuser !== prev_u))
          stall_viol++;
        if (o_tvalid && o_tready) rx_q.push_back('{o_tdata, o_tlast, o_tuser});
        if (len_err)  len_cnt++;
        if (seq_err)  seq_cnt++;
        if (drop_stb) drop_cnt++;
        prev_stall = o_tvalid && !o_tready;
        prev_d     = o_tdata;
        prev_u     = o_tuser;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_tx(input bit tlast_end, output bit ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < tx_q.size(); i++) begin
      i_tdata  = tx_q[i];
      i_tlast  = tlast_end && (i == tx_q.size() - 1);
      i_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!i_tready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!i_tready) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (o_tvalid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = !o_tvalid;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic send_pkt(input string nm, input logic [63:0] hdr, input int nw);
    bit ok;
    tx_q.delete();
    tx_q.push_back(hdr);
    for (int j = 0; j < nw; j++) tx_q.push_back(64'h0101_0000_0202_0000 + 64'(j));
    drive_tx(1'b1, ok);
    check({nm, "_tx"}, ok, 1);
  endtask

  task automatic set_vec(input int i, input logic [63:0] h, w0, w1, w2, input int nw, ns,
                         input logic [31:0] s0, s1, s2, s3, input int le, dr, ec);
    vt[i].hdr = h;
    vt[i].w   = {w2, w1, w0};
    vt[i].nw  = nw;
    vt[i].ns  = ns;
    vt[i].s   = {s3, s2, s1, s0};
    vt[i].le  = le;
    vt[i].dr  = dr;
    vt[i].ec  = ec;
  endtask

  task automatic run_vec(input int v);
    int          base, l0, d0, s0;
    bit          ok;
    logic [63:0] tm;
    do_clear();
    base = rx_q.size();
    l0 = len_cnt; d0 = drop_cnt; s0 = seq_cnt;
    tx_q.delete();
    tx_q.push_back(vt[v].hdr);
    for (int j = 0; j < vt[v].nw; j++) tx_q.push_back(vt[v].w[j]);
    drive_tx(1'b1, ok);
    check($sformatf("v%0d_tx", v), ok, 1);
    drain(ok);
    check($sformatf("v%0d_drain", v), ok, 1);
    tm = vt[v].hdr[61] ? vt[v].w[0] : 64'h0;
    check($sformatf("v%0d_nsamp", v), rx_q.size() - base, vt[v].ns);
    for (int k = 0; k < vt[v].ns && base + k < rx_q.size(); k++)
      check($sformatf("v%0d_s%0d", v, k),
            {rx_q[base+k].data, rx_q[base+k].last, rx_q[base+k].user},
            {vt[v].s[k], k == vt[v].ns - 1, vt[v].hdr, tm});
    check($sformatf("v%0d_len_err", v), len_cnt - l0, vt[v].le);
    check($sformatf("v%0d_drop", v), drop_cnt - d0, vt[v].dr);
    check($sformatf("v%0d_seq_err", v), seq_cnt - s0, 0);
    check($sformatf("v%0d_err_count", v), err_count, vt[v].ec);
  endtask

  // Packet-level reference: applies the framing rules to the words in tx_q.
  task automatic model_pkt();
    logic [63:0]  hdr, tm;
    logic [15:0]  len;
    int           n, pay, fd, left;
    bit           ht, hdr_err, is_end, fin;
    hdr = tx_q[0];
    n   = tx_q.size();
    len = hdr[47:32];
    ht  = hdr[61];
    pay = int'(len) - 8 - 8 * int'(ht);
    if (hdr[63:62] != 2'b00 || pay <= 0 || len[1:0] != 2'b00) begin
      e_drop++;
      if (len[1:0] != 2'b00) e_len++;
      e_ecnt++;
      return;
    end
    hdr_err = m_armed && (hdr[59:48] != m_exp);
    if (hdr_err) e_seq++;
    m_exp   = hdr[59:48] + 12'd1;
    m_armed = 1'b1;
    fd = 1 + int'(ht);
    if (n < fd + 1) begin
      e_len++;
      e_ecnt += (n == 1) ? 1 : int'(hdr_err) + 1;
      return;
    end
    e_ecnt += int'(hdr_err);
    tm = ht ? tx_q[1] : 64'h0;
    for (int i = fd; i < n; i++) begin
      left   = pay - 8 * (i - fd);
      is_end = (i == n - 1);
      fin    = (left <= 8) || is_end;
      exp_q.push_back('{tx_q[i][63:32], fin && !(left > 4), {hdr, tm}});
      if (left > 4) exp_q.push_back('{tx_q[i][31:0], fin, {hdr, tm}});
      if (fin) begin
        if (!(left <= 8 && is_end)) begin
          e_len++;
          e_ecnt++;
        end
        break;
      end
    end
  endtask

  initial begin
    int          base, l0, d0, s0, k, kind, nwp, plen, nw;
    bit          ok, ht;
    logic [1:0]  ty;
    logic [11:0] seq_r;
    logic [15:0] lenf;
    logic [63:0] hdr;

    set_vec(0,  64'h0000_0018_0001_0002, 64'h11112222_33334444, 64'h55556666_77778888, 64'h0, 2, 4,
            32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888, 0, 0, 0);
    set_vec(1,  64'h2000_0014_0003_0004, 64'h0000_0000_0000_1234, 64'hAAAAAAAA_BBBBBBBB, 64'h0, 2, 1,
            32'hAAAAAAAA, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    set_vec(2,  64'h0000_0028_0000_0000, 64'hC0000001_C0000002, 64'hC0000003_C0000004, 64'h0, 2, 4,
            32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004, 1, 0, 1);
    set_vec(3,  64'h0000_0010_0000_0000, 64'hD0000001_D0000002, 64'hD0000003_D0000004,
            64'hD0000005_D0000006, 3, 2, 32'hD0000001, 32'hD0000002, 32'h0, 32'h0, 1, 0, 1);
    set_vec(4,  64'h8000_0018_0000_0000, 64'hE0000001_E0000002, 64'hE0000003_E0000004, 64'h0, 2, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 1);
    set_vec(5,  64'h0000_0010_0005_0006, 64'h01234567_89ABCDEF, 64'h0, 64'h0, 1, 2,
            32'h01234567, 32'h89ABCDEF, 32'h0, 32'h0, 0, 0, 0);
    set_vec(6,  64'h0000_001A_0000_0000, 64'h1, 64'h2, 64'h0, 2, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 1);
    set_vec(7,  64'h0000_0008_0000_0000, 64'h0, 64'h0, 64'h0, 0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 1);
    set_vec(8,  64'h0000_0018_0000_0000, 64'h0, 64'h0, 64'h0, 0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1);
    set_vec(9,  64'h2000_0018_0000_0000, 64'h5555, 64'h0, 64'h0, 1, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1);
    set_vec(10, 64'h0000_0014_0000_0000, 64'hF0000001_F0000002, 64'hF0000003_F0000004,
            64'hF0000005_F0000006, 3, 3, 32'hF0000001, 32'hF0000002, 32'hF0000003, 32'h0, 1, 0, 1);

    reset = 1'b1; clear = 1'b0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    #12;
    check("reset_outputs", {o_tvalid, o_tlast, i_tready, o_tdata, o_tuser, len_err, seq_err,
                            drop_stb, err_count}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rdy_low_at_release", i_tready, 0);
    @(posedge clk); #1;
    check("rdy_high_first_edge", i_tready, 1);

    for (int v = 0; v < 11; v++) run_vec(v);

    // Sequence-number continuity.
    do_clear();
    s0 = seq_cnt;
    send_pkt("seq0", 64'h0000_0010_0000_0000, 1);
    send_pkt("seq1", 64'h0001_0010_0000_0000, 1);
    drain(ok);
    check("seq_first_two", seq_cnt - s0, 0);
    send_pkt("seq3", 64'h0003_0010_0000_0000, 1);
    drain(ok);
    check("seq_gap_err", seq_cnt - s0, 1);
    check("seq_gap_count", err_count, 1);
    do_clear();
    check("clear_count", err_count, 0);
    s0 = seq_cnt;
    send_pkt("seq4095", 64'h0FFF_0010_0000_0000, 1);
    send_pkt("seqwrap", 64'h0000_0010_0000_0000, 1);
    drain(ok);
    check("seq_wrap_ok", seq_cnt - s0, 0);
    check("seq_wrap_count", err_count, 0);

    // Saturation on the 2-bit counter instance.
    do_clear();
    for (int j = 0; j < 4; j++) send_pkt($sformatf("sat%0d", j), 64'h4000_0018_0000_0000, 0);
    drain(ok);
    check("sat_wide_count", err_count, 4);
    check("sat_narrow_count", err_count2, 3);
    do_clear();
    check("sat_cleared", err_count2, 0);

    // Random packets with random backpressure against the model.
    rand_rdy = 1'b1;
    do_clear();
    m_armed = 1'b0; m_exp = '0;
    exp_q.delete();
    e_len = 0; e_seq = 0; e_drop = 0; e_ecnt = 0;
    base = rx_q.size(); l0 = len_cnt; d0 = drop_cnt; s0 = seq_cnt;
    seq_r = 12'($urandom_range(0, 4095));
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 9);
      ht   = 1'($urandom_range(0, 1));
      nwp  = $urandom_range(1, 5);
      plen = nwp * 8 - 4 * $urandom_range(0, 1);
      lenf = 16'(8 + 8 * int'(ht) + plen);
      ty   = 2'b00;
      nw   = nwp;
      if (kind == 0) ty = 2'($urandom_range(1, 3));
      if (kind == 1) nw = nwp + $urandom_range(1, 2);
      if (kind == 2) nw = nwp - 1;
      if (kind == 4) lenf = lenf + 16'd2;
      seq_r = (kind == 3) ? 12'($urandom_range(0, 4095)) : seq_r + 12'd1;
      hdr = {ty, ht, 1'($urandom_range(0, 1)), seq_r, lenf, 32'($urandom())};
      tx_q.delete();
      tx_q.push_back(hdr);
      if (ht) tx_q.push_back({32'h0, 32'($urandom())});
      for (int j = 0; j < nw; j++) tx_q.push_back({32'($urandom()), 32'($urandom())});
      model_pkt();
      drive_tx(1'b1, ok);
      check($sformatf("rnd%0d_tx", p), ok, 1);
    end
    drain(ok);
    check("rnd_drain", ok, 1);
    check("rnd_nsamp", rx_q.size() - base, exp_q.size());
    for (int j = 0; j < exp_q.size() && base + j < rx_q.size(); j++)
      check($sformatf("rnd_s%0d", j), {rx_q[base+j].data, rx_q[base+j].last, rx_q[base+j].user},
            {exp_q[j].data, exp_q[j].last, exp_q[j].user});
    check("rnd_len_err", len_cnt - l0, e_len);
    check("rnd_seq_err", seq_cnt - s0, e_seq);
    check("rnd_drop", drop_cnt - d0, e_drop);
    check("rnd_err_count", err_count, e_ecnt);

    // Reset in the middle of a payload under random backpressure.
    tx_q.delete();
    tx_q.push_back(64'h0007_0048_0000_0000);
    for (int j = 0; j < 5; j++) tx_q.push_back({32'hA000_0000 + 32'(2*j), 32'hA000_0001 + 32'(2*j)});
    base = rx_q.size();
    drive_tx(1'b0, ok);
    check("rst_tx", ok, 1);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    reset = 1'b1;
    k = rx_q.size() - base;
    check("rst_prefix_len", (k >= 8) && (k <= 10), 1);
    for (int j = 0; j < k && j < 10; j++)
      check($sformatf("rst_s%0d", j), {rx_q[base+j].data, rx_q[base+j].last},
            {32'hA000_0000 + 32'(j), 1'b0});
    #1;
    check("rst_outputs", {o_tvalid, o_tlast, i_tready, o_tdata, o_tuser, len_err, seq_err,
                          drop_stb, err_count}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rdy_low", i_tready, 0);
    @(posedge clk); #1;
    check("rst_rdy_high", i_tready, 1);
    run_vec(0);

    check("out_stable_on_stall", stall_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
